// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I decode types, opcode constants and bubble encoding
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic br;
        logic jmp;
        logic jalr;
        logic alu_src_imm;
        logic alu_src_pc;
    } dec_ctrl_t;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    // alt selects SUB/SRA (funct7[5]) on the add and right-shift slots
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate from instruction bits by format
module imm_gen
    import cpu_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    // select the immediate layout; R-type and unknown formats give zero
    always_comb begin
        imm = fmt == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
              fmt == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              fmt == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              fmt == IMM_U ? {instr[31:12], 12'b0} :
              fmt == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              '0;
    end

endmodule

// File: rtl/decode.sv
// decode: one-cycle RV32I decode stage with load-use stall, flush and bubble insertion.
// Optional build macro DEC_ILLEGAL_EN adds b_dec_ex_illegal and issues undefined encodings flagged.
module decode
    import cpu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [31:0]     b_fetch_dec_instr,
    input  logic [XLEN-1:0] i_fetch_dec_pc,
    input  logic            i_fetch_dec_valid,
    input  logic            i_ex_stall,
    input  logic            i_flush,
    output logic            o_dec_stall,
    output logic            b_dec_ex_valid,
    output logic [XLEN-1:0] b_dec_ex_pc,
    output logic [4:0]      b_dec_ex_rs1,
    output logic [4:0]      b_dec_ex_rs2,
    output logic [4:0]      b_dec_ex_rd,
    output logic [XLEN-1:0] b_dec_ex_imm,
    output alu_op_e         b_dec_ex_alu_op,
    output dec_ctrl_t       b_dec_ex_ctrl
`ifdef DEC_ILLEGAL_EN
    ,
    output logic            b_dec_ex_illegal
`endif
);

    logic [6:0]      raw_opc;
    logic [31:0]     instr;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    imm_fmt_e        fmt;
    dec_ctrl_t       ctrl;
    alu_op_e         alu_op;
    logic            legal;
    logic            use1;
    logic            use2;
    logic            hazard;
    logic            go;
    logic [XLEN-1:0] imm;

    assign raw_opc = b_fetch_dec_instr[6:0];
    assign instr   = (raw_opc == OPC_FENCE || raw_opc == OPC_SYSTEM) ? NOP_INSTR : b_fetch_dec_instr;
    assign opc     = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];

    imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    // opcode decode into format, control bits, ALU op, legality and source usage
    always_comb begin
        fmt    = IMM_R;
        ctrl   = '0;
        alu_op = ALU_ADD;
        legal  = 1'b1;
        use1   = 1'b1;
        use2   = 1'b0;
        case (opc)
            OPC_LUI: begin
                fmt = IMM_U; use1 = 1'b0; alu_op = ALU_PASSB;
                ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; use1 = 1'b0;
                ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_src_pc = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J; use1 = 1'b0;
                ctrl.reg_we = 1'b1; ctrl.jmp = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_src_pc = 1'b1;
            end
            OPC_JALR: begin
                fmt = IMM_I; legal = f3 == 3'b000;
                ctrl.reg_we = 1'b1; ctrl.jmp = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = IMM_B; use2 = 1'b1; legal = f3[2:1] != 2'b01;
                alu_op = f3[2:1] == 2'b00 ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT;
                ctrl.br = 1'b1;
            end
            OPC_LOAD: begin
                fmt = IMM_I; legal = !(f3 == 3'b011 || f3[2:1] == 2'b11);
                ctrl.reg_we = 1'b1; ctrl.mem_re = 1'b1; ctrl.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                fmt = IMM_S; use2 = 1'b1; legal = f3 < 3'd3;
                ctrl.mem_we = 1'b1; ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt = IMM_I;
                alu_op = alu_from_funct(f3, f3 == 3'b101 && f7[5]);
                legal = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 & 7'b1011111) == 7'b0 : 1'b1;
                ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP: begin
                use2 = 1'b1;
                alu_op = alu_from_funct(f3, f7[5]);
                legal = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                ctrl.reg_we = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        ctrl.reg_we = ctrl.reg_we & (instr[11:7] != 5'd0);
    end

    // load-use hazard against the load currently sitting in execute
    always_comb begin
        hazard = b_dec_ex_valid & b_dec_ex_ctrl.mem_re & (b_dec_ex_rd != 5'd0) & i_fetch_dec_valid &
                 ((use1 & (instr[19:15] == b_dec_ex_rd)) | (use2 & (instr[24:20] == b_dec_ex_rd)));
`ifdef DEC_ILLEGAL_EN
        go = i_fetch_dec_valid & ~hazard & ~i_flush;
`else
        go = i_fetch_dec_valid & ~hazard & ~i_flush & legal;
`endif
        o_dec_stall = (i_ex_stall | hazard) & ~i_flush & i_rst_n;
    end

    // pipeline register: flush loads a bubble, ex stall holds, otherwise issue or bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            b_dec_ex_valid   <= 1'b0;
            b_dec_ex_pc      <= '0;
            b_dec_ex_rs1     <= '0;
            b_dec_ex_rs2     <= '0;
            b_dec_ex_rd      <= '0;
            b_dec_ex_imm     <= '0;
            b_dec_ex_alu_op  <= ALU_ADD;
            b_dec_ex_ctrl    <= '0;
`ifdef DEC_ILLEGAL_EN
            b_dec_ex_illegal <= 1'b0;
`endif
        end else if (i_flush || !i_ex_stall) begin
            b_dec_ex_valid   <= go;
            b_dec_ex_pc      <= go ? i_fetch_dec_pc : '0;
            b_dec_ex_rs1     <= go ? instr[19:15] : '0;
            b_dec_ex_rs2     <= go ? instr[24:20] : '0;
            b_dec_ex_rd      <= go ? instr[11:7] : '0;
            b_dec_ex_imm     <= go ? imm : '0;
            b_dec_ex_alu_op  <= go ? alu_op : ALU_ADD;
            b_dec_ex_ctrl    <= (go && legal) ? ctrl : '0;
`ifdef DEC_ILLEGAL_EN
            b_dec_ex_illegal <= go & ~legal;
`endif
        end
    end

endmodule
